// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the LC-3 memory responder.
package memresp_pkg;
  typedef enum logic [2:0] {IDLE, MEM_RD, MEM_WR, IO, DONE} resp_state_t;
  localparam logic [15:0] IO_ADDR_DEF = 16'hFFFF;
  localparam int          CNT_W       = 4;
endpackage

// File: rtl/mem_responder_if.sv
// CPU-side MAR/MDR request bus between the LC-3 datapath and the memory responder.
interface mem_responder_if;
  logic        Req_Rd;
  logic        Req_Wr;
  logic [15:0] Addr;
  logic [15:0] WData;
  logic [15:0] RData;
  logic        Ready;

  modport master (output Req_Rd, Req_Wr, Addr, WData, input  RData, Ready);
  modport slave  (input  Req_Rd, Req_Wr, Addr, WData, output RData, Ready);
endinterface

// File: rtl/mem_responder_sync2.sv
// Two-flop synchronizer for the asynchronous board switch inputs.
module sync2 #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta;
  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_q    <= '0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/mem_responder.sv
// LC-3 memory responder: sequences SRAM strobes with wait states, decodes one I/O address.
// Build option MEMRESP_SWSYNC_EN: route SW through a two-flop synchronizer before I/O reads.
module mem_responder
  import memresp_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = IO_ADDR_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  mem_responder_if.slave        bus,
  output logic [19:0]           SRAM_ADDR,
  output logic [15:0]           SRAM_DOUT,
  input  logic [15:0]           SRAM_DIN,
  output logic                  SRAM_CE_N,
  output logic                  SRAM_OE_N,
  output logic                  SRAM_WE_N,
  input  logic [15:0]           SW,
  output logic [15:0]           HEX_Data
);
  localparam logic [CNT_W-1:0] LP_CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  resp_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_addr;
  logic [15:0]      r_wdata;
  logic             r_is_wr;
  logic [15:0]      r_rdata;
  logic             r_ready;
  logic             r_ce_n;
  logic             r_oe_n;
  logic             r_we_n;
  logic [15:0]      r_hex;
  logic [15:0]      w_sw;
  logic             w_req;

`ifdef MEMRESP_SWSYNC_EN
  sync2 #(.W(16)) u_sw_sync (
    .i_clk   (Clk),
    .i_rst_n (Reset),
    .i_d     (SW),
    .o_q     (w_sw)
  );
`else
  assign w_sw = SW;
`endif

  assign w_req = bus.Req_Rd | bus.Req_Wr;

  // Strobes are registered alongside the state so they are low exactly while in MEM_RD/MEM_WR.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_is_wr <= 1'b0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_hex   <= '0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr  <= bus.Addr;
            r_wdata <= bus.WData;
            r_is_wr <= bus.Req_Wr;
            r_cnt   <= LP_CNT_LOAD;
            if (bus.Addr == IO_ADDR) begin
              r_state <= IO;
            end else if (bus.Req_Wr) begin
              r_ce_n  <= 1'b0;
              r_we_n  <= 1'b0;
              r_state <= MEM_WR;
            end else begin
              r_ce_n  <= 1'b0;
              r_oe_n  <= 1'b0;
              r_state <= MEM_RD;
            end
          end
        end
        MEM_RD: begin
          if (r_cnt == '0) begin
            r_rdata <= SRAM_DIN;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        MEM_WR: begin
          // WE_N rises while address and data are still held, giving the SRAM its hold time.
          if (r_cnt == '0) begin
            r_ce_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        IO: begin
          if (r_is_wr) r_hex   <= r_wdata;
          else         r_rdata <= w_sw;
          r_ready <= 1'b1;
          r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.RData = r_rdata;
  assign bus.Ready = r_ready;
  assign SRAM_ADDR = {4'b0000, r_addr};
  assign SRAM_DOUT = r_wdata;
  assign SRAM_CE_N = r_ce_n;
  assign SRAM_OE_N = r_oe_n;
  assign SRAM_WE_N = r_we_n;
  assign HEX_Data  = r_hex;
endmodule
